qam_mixer: RTL and testbench

Downstream of the two carrier generators: it takes the cosine and sine carrier samples and a stream of 4-bit 16-QAM symbols. Each symbol is mapped to Gray-coded I/Q levels and held for a programmable number of samples. The block produces the passband sample I·cos − Q·sin through a 2-stage multiply/sum pipeline. The output feeds the DAC interface.

---
 rtl/qam_mixer.sv | 139 +++++++++++++
 tb/tb_qam_mixer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/qam_mixer.sv
// -----------------------------------------------------------------------------
// qam_mixer
// 16-QAM passband mixer. Accepts 4-bit symbols, maps each one to Gray-coded
// I/Q levels held for sps samples, and produces qam_out = (I*cos - Q*sin) >>> 3
// through a two-stage multiply/sum pipeline.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   sps        samples per symbol, sampled at symbol load (0 treated as 1)
//   sym_data   symbol: [3:2] selects I level, [1:0] selects Q level
//   sym_valid  symbol present
//   sym_ready  symbol accepted this cycle (from state/counter only)
//   cos_wav    signed in-phase carrier sample
//   sin_wav    signed quadrature carrier sample
//   qam_out    signed modulated sample (registered)
//   out_valid  qam_out carries symbol-derived data
//   underrun   one-cycle pulse when a symbol boundary finds no symbol
// -----------------------------------------------------------------------------
module qam_mixer #(
    parameter int DATA_WIDTH = 32,
    parameter int SPS_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SPS_WIDTH-1:0]  sps,
    input  logic [3:0]            sym_data,
    input  logic                  sym_valid,
    output logic                  sym_ready,
    input  logic [DATA_WIDTH-1:0] cos_wav,
    input  logic [DATA_WIDTH-1:0] sin_wav,
    output logic [DATA_WIDTH-1:0] qam_out,
    output logic                  out_valid,
    output logic                  underrun
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]                  state_q, state_d;
    logic [SPS_WIDTH-1:0]        cnt_q, cnt_d;
    logic [SPS_WIDTH-1:0]        sps_q, sps_d;
    logic signed [2:0]           lvl_i_q, lvl_i_d;
    logic signed [2:0]           lvl_q_q, lvl_q_d;
    logic signed [DATA_WIDTH+2:0] p_i_q, p_i_d;
    logic signed [DATA_WIDTH+2:0] p_q_q, p_q_d;
    logic signed [DATA_WIDTH+2:0] sum;
    logic                        v1_q, v1_d;
    logic [DATA_WIDTH-1:0]       qam_out_q, qam_out_d;
    logic                        out_valid_q, out_valid_d;

    logic active;
    logic at_boundary;
    logic accept;

    // Gray-coded 4-level map shared by I and Q.
    function automatic logic signed [2:0] map_level(input logic [1:0] bits);
        logic signed [2:0] lvl;
        case (bits)
            2'b00:   lvl = -3'sd3;
            2'b01:   lvl = -3'sd1;
            2'b11:   lvl = 3'sd1;
            default: lvl = 3'sd3;
        endcase
        return lvl;
    endfunction

    assign active      = (state_q == ST_RUN);
    assign at_boundary = active && (cnt_q == sps_q - SPS_WIDTH'(1));
    assign sym_ready   = !active || at_boundary;
    assign accept      = sym_valid && sym_ready;
    assign underrun    = at_boundary && !sym_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sps_d   = sps_q;
        lvl_i_d = lvl_i_q;
        lvl_q_d = lvl_q_q;
        if (accept) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            sps_d   = (sps == '0) ? SPS_WIDTH'(1) : sps;
            lvl_i_d = map_level(sym_data[3:2]);
            lvl_q_d = map_level(sym_data[1:0]);
        end else if (at_boundary) begin
            // Boundary with no symbol waiting: drop back to idle silence.
            state_d = ST_IDLE;
            cnt_d   = '0;
            lvl_i_d = '0;
            lvl_q_d = '0;
        end else if (active) begin
            cnt_d = cnt_q + SPS_WIDTH'(1);
        end
    end

    // Operands are sign-extended to the full product width so the multiply
    // and subtract are exact; |sum| <= 6*2^(DATA_WIDTH-1) always fits.
    always_comb begin
        p_i_d       = $signed({{DATA_WIDTH{lvl_i_q[2]}}, lvl_i_q})
                    * $signed({{3{cos_wav[DATA_WIDTH-1]}}, cos_wav});
        p_q_d       = $signed({{DATA_WIDTH{lvl_q_q[2]}}, lvl_q_q})
                    * $signed({{3{sin_wav[DATA_WIDTH-1]}}, sin_wav});
        v1_d        = active;
        sum         = p_i_q - p_q_q;
        qam_out_d   = sum[DATA_WIDTH+2:3];
        out_valid_d = v1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sps_q       <= SPS_WIDTH'(1);
            lvl_i_q     <= '0;
            lvl_q_q     <= '0;
            p_i_q       <= '0;
            p_q_q       <= '0;
            v1_q        <= 1'b0;
            qam_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sps_q       <= sps_d;
            lvl_i_q     <= lvl_i_d;
            lvl_q_q     <= lvl_q_d;
            p_i_q       <= p_i_d;
            p_q_q       <= p_q_d;
            v1_q        <= v1_d;
            qam_out_q   <= qam_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign qam_out   = qam_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_qam_mixer.sv
// -----------------------------------------------------------------------------
// tb_qam_mixer
// Self-checking bench for qam_mixer. A reference model tracks "samples left
// in the current symbol" and the mapped levels, and a two-deep history of
// (levels, carriers, active) gives the expected pipelined output.
// -----------------------------------------------------------------------------
module tb_qam_mixer;

    localparam int DW = 32;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] sps;
    logic [3:0]    sym_data;
    logic          sym_valid;
    logic          sym_ready;
    logic [DW-1:0] cos_wav;
    logic [DW-1:0] sin_wav;
    logic [DW-1:0] qam_out;
    logic          out_valid;
    logic          underrun;

    always #5 clk = ~clk;

    qam_mixer #(.DATA_WIDTH(DW), .SPS_WIDTH(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sps       (sps),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .cos_wav   (cos_wav),
        .sin_wav   (sin_wav),
        .qam_out   (qam_out),
        .out_valid (out_valid),
        .underrun  (underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct {
        longint i;
        longint q;
        longint c;
        longint s;
        bit     act;
    } hist_t;

    int     m_left;
    longint m_i, m_q;
    hist_t  h1, h2;
    bit     last_acc;
    bit     cap_en;
    longint cap[$];
    int     ov_run, ov_max, und_cnt;

    function automatic longint level_of(input logic [1:0] b);
        case (b)
            2'b00:   return -3;
            2'b01:   return -1;
            2'b11:   return 1;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        m_left = 0;
        m_i    = 0;
        m_q    = 0;
        h1     = '{0, 0, 0, 0, 1'b0};
        h2     = '{0, 0, 0, 0, 1'b0};
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model.
    task automatic cyc(input bit v, input logic [3:0] d, input int sp,
                       input logic [DW-1:0] c, input logic [DW-1:0] s);
        logic signed [63:0] e;
        bit    rdy;
        hist_t cur;
        @(negedge clk);
        sym_valid = v;
        sym_data  = d;
        sps       = sp[SW-1:0];
        cos_wav   = c;
        sin_wav   = s;
        #1;
        rdy = (m_left <= 1);
        e   = (h2.i * h2.c - h2.q * h2.s) >>> 3;
        check("qam_out", $signed(qam_out), e);
        check("out_valid", {63'd0, out_valid}, {63'd0, h2.act});
        check("sym_ready", {63'd0, sym_ready}, {63'd0, rdy});
        check("underrun", {63'd0, underrun}, {63'd0, (m_left == 1) && !v});
        if (cap_en && out_valid) cap.push_back(longint'($signed(qam_out)));
        if (out_valid) ov_run++; else ov_run = 0;
        if (ov_run > ov_max) ov_max = ov_run;
        if (underrun) und_cnt++;
        cur = '{m_i, m_q, longint'($signed(c)), longint'($signed(s)), m_left > 0};
        h2 = h1;
        h1 = cur;
        last_acc = v && rdy;
        if (last_acc) begin
            m_left = (sp[SW-1:0] == 0) ? 1 : int'(sp[SW-1:0]);
            m_i    = level_of(d[3:2]);
            m_q    = level_of(d[1:0]);
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_i = 0;
                m_q = 0;
            end
        end
    endtask

    // Hold a symbol valid until the model says it was taken (bounded).
    task automatic send(input logic [3:0] d, input int sp,
                        input logic [DW-1:0] c, input logic [DW-1:0] s);
        int n = 0;
        do begin
            cyc(1'b1, d, sp, c, s);
            n++;
        end while (!last_acc && n < 100);
        check("accept", {63'd0, last_acc}, 64'sd1);
    endtask

    task automatic idle(input int n, input logic [DW-1:0] c, input logic [DW-1:0] s);
        for (int k = 0; k < n; k++) cyc(1'b0, 4'($urandom), 1, c, s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        sym_valid = 1'b0;
        #1;
        check("rst_qam_out", $signed(qam_out), 0);
        check("rst_out_valid", {63'd0, out_valid}, 0);
        check("rst_sym_ready", {63'd0, sym_ready}, 1);
        check("rst_underrun", {63'd0, underrun}, 0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_hold_qam_out", $signed(qam_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    localparam logic [DW-1:0] C1000 = 32'd1000;
    localparam logic [DW-1:0] C8000 = 32'd8000;

    initial begin
        longint exp_lm[4];
        exp_lm = '{375, 125, -125, -375};
        rst_n = 1'b0; sym_valid = 1'b0; sym_data = '0; sps = '0;
        cos_wav = '0; sin_wav = '0;
        cap_en = 1'b0; ov_run = 0; ov_max = 0; und_cnt = 0;
        model_reset();
        do_reset();
        idle(6, 32'($urandom), 32'($urandom));

        // Level map, back to back at sps = 4.
        cap.delete(); cap_en = 1'b1;
        send(4'b1000, 4, C1000, '0);
        send(4'b1100, 4, C1000, '0);
        send(4'b0100, 4, C1000, '0);
        send(4'b0000, 4, C1000, '0);
        idle(6, C1000, '0);
        cap_en = 1'b0;
        check("lm_count", cap.size(), 16);
        for (int k = 0; k < 16 && k < cap.size(); k++) check("lm_value", cap[k], exp_lm[k/4]);

        // Quadrature path.
        cap.delete(); cap_en = 1'b1;
        send(4'b0010, 2, '0, C8000);
        idle(4, '0, C8000);
        send(4'b0010, 2, C8000, C8000);
        idle(4, C8000, C8000);
        cap_en = 1'b0;
        check("quad_count", cap.size(), 4);
        if (cap.size() == 4) begin
            check("quad_sin_only", cap[0], -3000);
            check("quad_both", cap[2], -6000);
        end

        // Full scale: I=+3, Q=+3 against max positive cos and max negative sin.
        cap.delete(); cap_en = 1'b1;
        send(4'b1010, 1, 32'h7FFF_FFFF, 32'h8000_0000);
        idle(4, 32'h7FFF_FFFF, 32'h8000_0000);
        cap_en = 1'b0;
        check("fs_count", cap.size(), 1);
        if (cap.size() == 1) check("fs_value", cap[0], 64'sh5FFF_FFFF);
        send(4'b1000, 1, 32'h7FFF_FFFF, 32'h8000_0000);
        idle(4, 32'h7FFF_FFFF, 32'h8000_0000);

        // Streaming, sps = 5, then underrun.
        ov_max = 0; und_cnt = 0;
        for (int k = 0; k < 3; k++) send(4'($urandom), 5, 32'($urandom), 32'($urandom));
        idle(8, 32'($urandom), 32'($urandom));
        check("stream_ov_run", ov_max, 15);
        check("stream_underrun", und_cnt, 1);

        // sps = 0 behaves as one sample per symbol.
        ov_max = 0; und_cnt = 0;
        for (int k = 0; k < 4; k++) send(4'($urandom), 0, 32'($urandom), 32'($urandom));
        idle(5, 32'($urandom), 32'($urandom));
        check("sps0_ov_run", ov_max, 4);
        check("sps0_underrun", und_cnt, 1);

        // Random traffic.
        for (int k = 0; k < 600; k++)
            cyc(($urandom % 4) != 0, 4'($urandom), int'($urandom_range(0, 5)),
                32'($urandom), 32'($urandom));
        idle(8, 32'($urandom), 32'($urandom));

        // Mid-symbol reset at cnt = 2 of an sps = 8 symbol.
        send(4'b1010, 8, C1000, C1000);
        cyc(1'b0, '0, 8, C1000, C1000);
        cyc(1'b0, '0, 8, C1000, C1000);
        do_reset();
        idle(3, C1000, C1000);
        send(4'b1111, 3, C1000, '0);
        idle(6, C1000, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
